// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared CPU pipeline constants for the HI/LO multiply-divide unit
package muldiv_unit_pkg;
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } muldiv_op_e;
    typedef enum logic {IDLE, BUSY} muldiv_state_e;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle mult/div with HI/LO registers; clk, reset, start/op/rs_E/rt_E in, busy/hi/lo out
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_CYCLES = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    muldiv_state_e state, next_state;
    logic [CW-1:0] cnt;
    logic [31:0] a, b;
    logic [2:0] op_q;
    logic accept, done, sgn;
    logic [63:0] prod;
    logic [31:0] abs_a, abs_b, dvs, uq, ur, q, r;
    assign accept = state == IDLE && start && !op[2];
    assign done = state == BUSY && cnt == CW'(1);
    assign busy = state == BUSY;
    always_ff @(posedge clk)
        state <= reset ? IDLE : next_state;
    always_comb
        next_state = accept ? BUSY : done ? IDLE : state;
    // signed division works on magnitudes, then restores signs (quotient truncates toward zero)
    always_comb begin
        sgn   = !op_q[0];
        prod  = sgn ? {{32{a[31]}}, a} * {{32{b[31]}}, b} : {32'b0, a} * {32'b0, b};
        abs_a = sgn && a[31] ? -a : a;
        abs_b = sgn && b[31] ? -b : b;
        dvs   = abs_b == 32'd0 ? 32'd1 : abs_b;
        uq    = abs_a / dvs;
        ur    = abs_a % dvs;
        q     = sgn && (a[31] ^ b[31]) ? -uq : uq;
        r     = sgn && a[31] ? -ur : ur;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            a    <= '0;
            b    <= '0;
            op_q <= '0;
            cnt  <= '0;
        end else if (accept) begin
            a    <= rs_E;
            b    <= rt_E;
            op_q <= op;
            cnt  <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (state == IDLE && start && op == OP_MTHI) begin
            hi <= rs_E;
        end else if (state == IDLE && start && op == OP_MTLO) begin
            lo <= rs_E;
        end else if (busy) begin
            cnt <= cnt - CW'(1);
            if (done && !(op_q[1] && b == 32'd0))
                {hi, lo} <= op_q[1] ? {r, q} : prod;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] rs_E = '0;
    logic [31:0] rt_E = '0;
    logic        busy;
    logic [31:0] hi, lo;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int tests = 0;
    int failed = 0;

    muldiv_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_E(rs_E), .rt_E(rt_E), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // issue one request from IDLE and follow it to completion; noise drives random starts/operands while busy
    task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit noise);
        longint sx, sy, qq, rr;
        logic [63:0] p;
        logic [31:0] eh, el;
        int n, cycles;
        bit wr;
        eh = m_hi;
        el = m_lo;
        wr = 1'b0;
        n = 0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd0: begin p = 64'(sx * sy); {eh, el} = p; wr = 1'b1; n = MULT_N; end
            3'd1: begin p = {32'b0, x} * {32'b0, y}; {eh, el} = p; wr = 1'b1; n = MULT_N; end
            3'd2: begin
                n = DIV_N;
                if (y != 0) begin qq = sx / sy; rr = sx % sy; el = qq[31:0]; eh = rr[31:0]; wr = 1'b1; end
            end
            3'd3: begin
                n = DIV_N;
                if (y != 0) begin el = x / y; eh = x % y; wr = 1'b1; end
            end
            3'd4: begin eh = x; wr = 1'b1; end
            3'd5: begin el = x; wr = 1'b1; end
            default: ;
        endcase
        @(negedge clk);
        start = 1'b1; op = o; rs_E = x; rt_E = y;
        @(negedge clk);
        start = 1'b0;
        if (n == 0) begin
            check("no_busy", {63'b0, busy}, 64'd0);
        end else begin
            cycles = 0;
            while (busy && cycles < 100) begin
                cycles++;
                if (noise) begin
                    start = 1'($urandom_range(0, 1));
                    op = 3'($urandom_range(0, 7));
                    rs_E = $urandom;
                    rt_E = $urandom;
                end
                @(negedge clk);
            end
            start = 1'b0;
            check("busy_len", 64'(cycles), 64'(n));
        end
        if (wr) begin m_hi = eh; m_lo = el; end
        check("hi", {32'b0, hi}, {32'b0, m_hi});
        check("lo", {32'b0, lo}, {32'b0, m_lo});
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_hi", {32'b0, hi}, 64'd0);
        check("rst_lo", {32'b0, lo}, 64'd0);
        reset = 1'b0;
        run(3'd0, 32'hFFFFFFFF, 32'd2, 1'b0);
        check("mult_hi", {32'b0, hi}, 64'hFFFFFFFF);
        check("mult_lo", {32'b0, lo}, 64'hFFFFFFFE);
        run(3'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
        check("multu_hi", {32'b0, hi}, 64'h1);
        check("multu_lo", {32'b0, lo}, 64'hFFFFFFFE);
        run(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
        check("div_lo", {32'b0, lo}, 64'hFFFFFFFD);
        check("div_hi", {32'b0, hi}, 64'hFFFFFFFF);
        run(3'd3, 32'd100, 32'd0, 1'b0);
        check("divz_lo", {32'b0, lo}, 64'hFFFFFFFD);
        run(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        check("ovf_lo", {32'b0, lo}, 64'h80000000);
        check("ovf_hi", {32'b0, hi}, 64'h0);
        run(3'd4, 32'h12345678, 32'd0, 1'b0);
        check("mthi", {32'b0, hi}, 64'h12345678);
        run(3'd5, 32'hCAFEF00D, 32'd0, 1'b0);
        run(3'd6, 32'h11111111, 32'd3, 1'b0);
        run(3'd7, 32'h22222222, 32'd3, 1'b0);
        // mthi offered throughout a div must not touch hi
        @(negedge clk);
        start = 1'b1; op = 3'd2; rs_E = 32'd50; rt_E = 32'd7;
        @(negedge clk);
        op = 3'd4; rs_E = 32'hDEADBEEF;
        for (int i = 0; i < DIV_N; i++) @(negedge clk);
        start = 1'b0;
        m_hi = 32'd1; m_lo = 32'd7;
        check("mthi_busy_hi", {32'b0, hi}, 64'd1);
        check("mthi_busy_lo", {32'b0, lo}, 64'd7);
        run(3'd0, 32'd1234, 32'hFFFFFFFD, 1'b1);
        // reset on the 4th busy cycle aborts the div
        @(negedge clk);
        start = 1'b1; op = 3'd3; rs_E = 32'd99; rt_E = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_hi", {32'b0, hi}, 64'd0);
        check("abort_lo", {32'b0, lo}, 64'd0);
        repeat (DIV_N) @(negedge clk);
        check("abort_late_lo", {32'b0, lo}, 64'd0);
        for (int i = 0; i < 60; i++) begin
            logic [31:0] x, y;
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 5))
                0: y = 32'd0;
                1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
                2: y = 32'($urandom_range(1, 9));
                default: ;
            endcase
            run(3'($urandom_range(0, 7)), x, y, 1'($urandom_range(0, 1)));
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
